sync_fifo: RTL and testbench

Single-clock, first-word-fall-through byte FIFO with registered occupancy tracking and a debug port for pointers and count. It decouples a producer and a consumer that run on the same clock, for example between the SPI front end and the host/USB side. Both sides use a level-status/single-cycle-strobe handshake.

---
 rtl/sync_fifo.sv | 94 +++++++++
 tb/tb_sync_fifo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock, first-word-fall-through FIFO with registered
// occupancy count, level status outputs and a debug view of pointers/count.
// Any depth from 2 to 255 is supported, including depths that are not a power of two.
module sync_fifo #(
   parameter int NUM   = 4,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] write_data,
   input  logic             write_strobe,
   output logic             space_available,
   output logic [WIDTH-1:0] read_data,
   input  logic             read_strobe,
   output logic             data_available,
   output logic [7:0]       write_ptr,
   output logic [7:0]       read_ptr,
   output logic [7:0]       count
);

   localparam int PTR_W = $clog2(NUM);

   typedef logic [PTR_W-1:0] ptr_t;

   localparam ptr_t       LAST_IDX   = ptr_t'(NUM - 1);
   localparam logic [7:0] FULL_COUNT = 8'(NUM);

   // Pointers wrap explicitly at NUM-1, so no power-of-two depth is assumed.
   function automatic ptr_t next_ptr(input ptr_t p);
      return (p == LAST_IDX) ? '0 : p + ptr_t'(1);
   endfunction

   logic [WIDTH-1:0] mem [NUM];
   ptr_t             wr_idx;
   ptr_t             rd_idx;
   logic             full;
   logic             empty;
   logic             write_accept;
   logic             read_accept;
   logic [7:0]       count_next;

   // Status comes straight from the count register. The two accept terms look
   // only at the count before the edge. A write to a full FIFO is therefore
   // dropped, even when a read frees an entry at that same edge.
   assign full         = (count == FULL_COUNT);
   assign empty        = (count == 8'd0);
   assign write_accept = write_strobe && !full;
   assign read_accept  = read_strobe && !empty;

   // Next occupancy. When a write and a read are both accepted, the count does not change.
   always_comb begin
      // NOTE: give every always_comb output a default first so no path can infer a latch.
      count_next = count;
      unique case ({write_accept, read_accept})
         2'b10:   count_next = count + 8'd1;
         2'b01:   count_next = count - 8'd1;
         default: count_next = count;
      endcase
   end

   // Pointer and count registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: sequential state uses non-blocking (<=) only, so every register samples pre-edge values.
         wr_idx <= '0;
         rd_idx <= '0;
         count  <= 8'd0;
      end else begin
         if (write_accept) wr_idx <= next_ptr(wr_idx);
         if (read_accept)  rd_idx <= next_ptr(rd_idx);
         count <= count_next;
      end
   end

   // Storage array. It is cleared on reset so that read_data reads 0 while reset is held.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         // NOTE: clearing the memory in reset makes it flops rather than RAM, which is fine at this size.
         for (int i = 0; i < NUM; i++) mem[i] <= '0;
      end else if (write_accept) begin
         mem[wr_idx] <= write_data;
      end
   end

   // First-word-fall-through: the head entry is always visible on read_data.
   assign read_data       = mem[rd_idx];
   assign data_available  = !empty;
   assign space_available = !full;

   // Debug view: the pointers zero-extended to 8 bits.
   assign write_ptr = 8'(wr_idx);
   assign read_ptr  = 8'(rd_idx);

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed bench for sync_fifo with NUM=4 and WIDTH=8.
// Every expected value is a hand-computed constant taken from the FIFO's defined behaviour.
module tb_sync_fifo;

   logic       clk;
   logic       reset;
   logic [7:0] write_data;
   logic       write_strobe;
   logic       space_available;
   logic [7:0] read_data;
   logic       read_strobe;
   logic       data_available;
   logic [7:0] write_ptr;
   logic [7:0] read_ptr;
   logic [7:0] count;

   int checks = 0;
   int errors = 0;

   sync_fifo #(.NUM(4), .WIDTH(8)) dut (
      .clk             (clk),
      .reset           (reset),
      .write_data      (write_data),
      .write_strobe    (write_strobe),
      .space_available (space_available),
      .read_data       (read_data),
      .read_strobe     (read_strobe),
      .data_available  (data_available),
      .write_ptr       (write_ptr),
      .read_ptr        (read_ptr),
      .count           (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance past the next rising edge. Inputs change and outputs are sampled 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      write_strobe = 1'b0;
      read_strobe  = 1'b0;
      reset        = 1'b0;
      step();
      step();
      reset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      write_strobe = 1'b0;
      read_strobe  = 1'b0;
      write_data   = 8'h00;
      reset        = 1'b0;
      #3;
      checks++; if (count !== 8'd0 || write_ptr !== 8'd0 || read_ptr !== 8'd0) begin
         errors++; $display("FAIL reset_during_state: count=%0d wp=%0d rp=%0d expected 0/0/0", count, write_ptr, read_ptr); end
      checks++; if (data_available !== 1'b0 || space_available !== 1'b1 || read_data !== 8'h00) begin
         errors++; $display("FAIL reset_during_flags: da=%b sa=%b rd=%h expected 0/1/00", data_available, space_available, read_data); end
      step();
      step();
      reset = 1'b1;
      step();
      checks++; if (count !== 8'd0 || write_ptr !== 8'd0 || read_ptr !== 8'd0 ||
                    data_available !== 1'b0 || space_available !== 1'b1 || read_data !== 8'h00) begin
         errors++; $display("FAIL reset_after: count=%0d wp=%0d rp=%0d da=%b sa=%b rd=%h expected 0/0/0/0/1/00",
                            count, write_ptr, read_ptr, data_available, space_available, read_data); end
   endtask

   task automatic test_single_entry();
      write_data   = 8'h01;
      write_strobe = 1'b1;
      step();
      write_strobe = 1'b0;
      checks++; if (data_available !== 1'b1 || read_data !== 8'h01 || count !== 8'd1 || write_ptr !== 8'd1) begin
         errors++; $display("FAIL single_write: da=%b rd=%h count=%0d wp=%0d expected 1/01/1/1",
                            data_available, read_data, count, write_ptr); end
      read_strobe = 1'b1;
      step();
      read_strobe = 1'b0;
      checks++; if (count !== 8'd0 || data_available !== 1'b0 || read_ptr !== 8'd1) begin
         errors++; $display("FAIL single_read: count=%0d da=%b rp=%0d expected 0/0/1", count, data_available, read_ptr); end
   endtask

   task automatic test_fill_overflow();
      logic [7:0] exp_head [4];
      exp_head = '{8'h01, 8'h02, 8'h03, 8'h04};
      apply_reset();
      for (int i = 1; i <= 4; i++) begin
         write_data   = 8'(i);
         write_strobe = 1'b1;
         step();
      end
      checks++; if (count !== 8'd4 || space_available !== 1'b0 || write_ptr !== 8'd0) begin
         errors++; $display("FAIL fill_full: count=%0d sa=%b wp=%0d expected 4/0/0", count, space_available, write_ptr); end
      write_data = 8'h05;
      step();
      write_strobe = 1'b0;
      checks++; if (count !== 8'd4 || write_ptr !== 8'd0 || read_data !== 8'h01) begin
         errors++; $display("FAIL overflow_dropped: count=%0d wp=%0d rd=%h expected 4/0/01", count, write_ptr, read_data); end
      read_strobe = 1'b1;
      for (int i = 0; i < 4; i++) begin
         checks++; if (read_data !== exp_head[i]) begin
            errors++; $display("FAIL drain_order[%0d]: rd=%h expected %h", i, read_data, exp_head[i]); end
         step();
         if (i == 0) begin
            checks++; if (space_available !== 1'b1) begin
               errors++; $display("FAIL space_after_read: sa=%b expected 1", space_available); end
         end
      end
      read_strobe = 1'b0;
      checks++; if (data_available !== 1'b0 || count !== 8'd0 || read_ptr !== 8'd0) begin
         errors++; $display("FAIL drain_empty: da=%b count=%0d rp=%0d expected 0/0/0", data_available, count, read_ptr); end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp_head [3];
      exp_head = '{8'h10, 8'h11, 8'h12};
      apply_reset();
      write_strobe = 1'b1;
      write_data   = 8'h10; step();
      write_data   = 8'h11; step();
      read_strobe  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         write_data = 8'h12 + 8'(i);
         checks++; if (read_data !== exp_head[i] || count !== 8'd2) begin
            errors++; $display("FAIL b2b_stream[%0d]: rd=%h count=%0d expected %h/2", i, read_data, count, exp_head[i]); end
         step();
      end
      write_strobe = 1'b0;
      read_strobe  = 1'b0;
      checks++; if (count !== 8'd2 || write_ptr !== 8'd1 || read_ptr !== 8'd3 || read_data !== 8'h13) begin
         errors++; $display("FAIL b2b_final: count=%0d wp=%0d rp=%0d rd=%h expected 2/1/3/13",
                            count, write_ptr, read_ptr, read_data); end
   endtask

   task automatic test_full_simultaneous();
      logic [7:0] exp_head [3];
      exp_head = '{8'h14, 8'h15, 8'h16};
      // Starts from the state test_back_to_back leaves behind: count=2, 0x13 and 0x14 held.
      write_strobe = 1'b1;
      write_data   = 8'h15; step();
      write_data   = 8'h16; step();
      checks++; if (count !== 8'd4 || space_available !== 1'b0) begin
         errors++; $display("FAIL refill_full: count=%0d sa=%b expected 4/0", count, space_available); end
      write_data  = 8'h77;
      read_strobe = 1'b1;
      step();
      write_strobe = 1'b0;
      read_strobe  = 1'b0;
      checks++; if (count !== 8'd3 || write_ptr !== 8'd3 || read_ptr !== 8'd0 || read_data !== 8'h14) begin
         errors++; $display("FAIL full_both: count=%0d wp=%0d rp=%0d rd=%h expected 3/3/0/14",
                            count, write_ptr, read_ptr, read_data); end
      read_strobe = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++; if (read_data !== exp_head[i]) begin
            errors++; $display("FAIL full_both_drain[%0d]: rd=%h expected %h", i, read_data, exp_head[i]); end
         step();
      end
      read_strobe = 1'b0;
      checks++; if (count !== 8'd0 || data_available !== 1'b0) begin
         errors++; $display("FAIL full_both_empty: count=%0d da=%b expected 0/0", count, data_available); end
   endtask

   task automatic test_underflow();
      // The FIFO is empty here with read_ptr=3, as test_full_simultaneous leaves it.
      read_strobe = 1'b1;
      step();
      step();
      read_strobe = 1'b0;
      checks++; if (read_ptr !== 8'd3 || count !== 8'd0 || data_available !== 1'b0 || space_available !== 1'b1) begin
         errors++; $display("FAIL underflow: rp=%0d count=%0d da=%b sa=%b expected 3/0/0/1",
                            read_ptr, count, data_available, space_available); end
   endtask

   task automatic test_async_reset();
      write_strobe = 1'b1;
      for (int i = 0; i < 3; i++) begin
         write_data = 8'hA1 + 8'(i);
         step();
      end
      write_strobe = 1'b0;
      checks++; if (count !== 8'd3 || write_ptr !== 8'd2 || read_data !== 8'hA1) begin
         errors++; $display("FAIL pre_async: count=%0d wp=%0d rd=%h expected 3/2/a1", count, write_ptr, read_data); end
      #2;
      reset = 1'b0;
      #1;
      checks++; if (count !== 8'd0 || write_ptr !== 8'd0 || read_ptr !== 8'd0 || data_available !== 1'b0 ||
                    space_available !== 1'b1 || read_data !== 8'h00) begin
         errors++; $display("FAIL async_reset: count=%0d wp=%0d rp=%0d da=%b sa=%b rd=%h expected 0/0/0/0/1/00",
                            count, write_ptr, read_ptr, data_available, space_available, read_data); end
      write_strobe = 1'b1;
      write_data   = 8'hEE;
      step();
      write_strobe = 1'b0;
      checks++; if (count !== 8'd0 || write_ptr !== 8'd0 || read_data !== 8'h00) begin
         errors++; $display("FAIL strobe_in_reset: count=%0d wp=%0d rd=%h expected 0/0/00", count, write_ptr, read_data); end
      reset = 1'b1;
      step();
   endtask

   initial begin
      test_reset();
      test_single_entry();
      test_fill_overflow();
      test_back_to_back();
      test_full_simultaneous();
      test_underflow();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
